// File: rtl/aes_key_sched_arbiter.sv
// Session arbiter in front of the shared AES-128 key-expansion engine.
// Grants sessions round-robin, skips re-expansion on a cached key, and serves round-key reads.
module aes_key_sched_arbiter #(
    parameter int KX_TIMEOUT = 15,
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req_valid,
    input  logic [127:0] req_key0,
    input  logic [127:0] req_key1,
    output logic [1:0]   grant,
    output logic         busy,
    input  logic         rd_en,
    input  logic [3:0]   rd_round,
    output logic [127:0] rk_out,
    output logic         rk_valid,
    output logic         kx_start,
    output logic [127:0] kx_key,
    input  logic         kx_done,
    output logic [3:0]   kx_round,
    input  logic [127:0] kx_round_key,
    output logic         key_cached,
    output logic         err_timeout
);

    localparam int TMO_W = ($clog2(KX_TIMEOUT + 1) > 4) ? $clog2(KX_TIMEOUT + 1) : 4;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(KX_TIMEOUT);
    localparam logic [3:0] MAX_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_SERVE
    } state_t;

    state_t             state;
    logic               owner;
    logic               rr_last;
    logic [127:0]       cached_key;
    logic               key_loaded;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               winner;
    logic [127:0]       winner_key;
    logic               cache_hit;

    // With both requesters pending, the one that did not own the last session wins.
    always_comb begin
        winner = 1'b0;
        if (req_valid == 2'b11) begin
            winner = ~rr_last;
        end else begin
            winner = req_valid[1];
        end
        winner_key = winner ? req_key1 : req_key0;
        cache_hit  = key_loaded && (winner_key == cached_key);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            rr_last     <= 1'b1;
            cached_key  <= '0;
            key_loaded  <= 1'b0;
            tmo_cnt     <= '0;
            kx_key      <= '0;
            kx_start    <= 1'b0;
            grant       <= 2'b00;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            kx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        owner <= winner;
                        busy  <= 1'b1;
                        if (cache_hit) begin
                            state <= ST_SERVE;
                            grant <= winner ? 2'b10 : 2'b01;
                        end else begin
                            kx_key      <= winner_key;
                            key_loaded  <= 1'b0;
                            err_timeout <= 1'b0;
                            tmo_cnt     <= '0;
                            kx_start    <= 1'b1;
                            state       <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    // A completion arriving on the timeout cycle still counts as success.
                    if (kx_done) begin
                        cached_key <= kx_key;
                        key_loaded <= 1'b1;
                        if (req_valid[owner]) begin
                            state <= ST_SERVE;
                            grant <= owner ? 2'b10 : 2'b01;
                        end else begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            rr_last <= owner;
                        end
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        err_timeout <= 1'b1;
                        rr_last     <= owner;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (!req_valid[owner]) begin
                        state   <= ST_IDLE;
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                        rr_last <= owner;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Round 0 is the cipher key itself, so it comes from the cache rather than the engine.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rk_out   <= '0;
            rk_valid <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            if (state == ST_SERVE && rd_en) begin
                if (rd_round == 4'd0) begin
                    rk_out   <= cached_key;
                    rk_valid <= 1'b1;
                end else if (rd_round <= MAX_ROUND) begin
                    rk_out   <= kx_round_key;
                    rk_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        kx_round = 4'd0;
        if (state == ST_SERVE && rd_en) begin
            kx_round = rd_round;
        end
    end

    assign key_cached = key_loaded;

endmodule
